sprite_rom_fetch: RTL and testbench
===================================

// Module: sprite_rom_fetch
// PURPOSE
//  Pixel-stream stage placed directly upstream of the 1024x12 image ROM (RGB444 words, 1-cycle synchronous read).
//  Tracks raster x/y from incoming DE/HS/VS and computes the ROM address for a scaled 32x32 sprite window.
//  Merges ROM data (with colour-key transparency) over a background colour, producing RGB888.
//  Delays DE/HS/VS so they stay aligned with the pixel; output feeds the TMDS/DVI encoder.
// PARAMETERS
//  IMG_W      32       sprite width in texels (power of two)
//  IMG_H      32       sprite height in texels; IMG_W*IMG_H <= 1024
//  SHIFT      2        scale = 2**SHIFT screen pixels per texel (0..3)
//  SYNC_POL   1'b0     active level of vid_hs/vid_vs (0 = active-low)
//  BG_COLOR   24'h000000  RGB888 outside the sprite or under the key colour
//  KEY_COLOR  12'h000  RGB444 texel value treated as transparent
//  KEY_EN     1'b1     1 = colour keying enabled
// PORTS
//  clk        in   1   pixel clock
//  rst_n      in   1   asynchronous active-low reset
//  vid_de     in   1   input data enable (active area)
//  vid_hs     in   1   input horizontal sync
//  vid_vs     in   1   input vertical sync
//  pos_x      in   12  sprite left edge, screen pixels; sampled at VS active edge
//  pos_y      in   12  sprite top edge, screen lines; sampled at VS active edge
//  rom_ad     out  10  ROM address
//  rom_ce     out  1   ROM clock enable
//  rom_oce    out  1   ROM output clock enable
//  rom_wre    out  1   ROM write enable, constant 0
//  rom_dout   in   12  ROM read data, {R[11:8],G[7:4],B[3:0]}, valid 1 cycle after rom_ad is clocked
//  out_de     out  1   delayed DE
//  out_hs     out  1   delayed HS
//  out_vs     out  1   delayed VS
//  out_rgb    out  24  {R8,G8,B8}
// BEHAVIOUR
//  Reset: all registers, including x/y counters, latched positions, pipeline and valid flag, clear to 0.
//   out_de=0, out_rgb=0. out_hs/out_vs = ~SYNC_POL (inactive). rom_ad=0, rom_ce=1, rom_oce=1, rom_wre=0.
//  Counters (stage 0, cycle N):
//   x increments on each de=1 cycle and clears on the first cycle with de=0.
//   y increments on each de falling edge and clears on the VS active edge.
//   x and y saturate at 4095; they do not wrap.
//  Frame lock: frame_ok is 0 after reset and sets on the first VS active edge.
//   While frame_ok=0, the sprite is suppressed and active pixels output BG_COLOR.
//  Position latch: pos_x/pos_y are captured only on the VS active edge (double-buffered).
//   Mid-frame changes to pos_x/pos_y have no effect until the next frame.
//  Window test: hit = de & frame_ok & x in [px, px+IMG_W<<SHIFT) & y in [py, py+IMG_H<<SHIFT).
//   Compare in 13-bit arithmetic so px+width never overflows.
//  Address: rom_ad = ((y-py)>>SHIFT)*IMG_W + ((x-px)>>SHIFT), registered at end of cycle N.
//   When hit=0, rom_ad holds its previous value.
//  Pipeline: ROM data is valid in N+2. out_* is registered at end of N+2, valid in N+3.
//   Fixed latency is 3 cycles for de, hs, vs, rgb and hit.
//  Colour: texel nibble n expands to {n,n} (4'hF -> 8'hFF).
//   out_rgb = BG_COLOR when out_de & (!hit_d | (KEY_EN & texel==KEY_COLOR)).
//   out_rgb = 0 whenever out_de=0 (blanking).
//  Clipping: a sprite extending past the active area is clipped naturally; address stays in range.
//  Reset mid-frame: outputs return to reset values immediately (async).
//   After release, frame_ok=0, so only BG_COLOR is shown until the next VS.
// TESTING
//  1 Reset held, random DE/HS/VS -> out_de=0, out_rgb=0, out_hs=out_vs=1 (SYNC_POL=0); release -> BG until first VS.
//  2 640x480 timing, pos=(100,50), SHIFT=2 -> screen x=100..227, y=50..177 carry sprite; pixel (104,54) reads rom_ad=33; (99,50) and (228,50) read BG.
//  3 Latency: single DE pulse at x=pos_x -> out_de high exactly 3 cycles later; hs/vs edges delayed by exactly 3.
//  4 ROM model returns 12'h000 at addr 0 with KEY_EN=1 -> BG_COLOR; texel 12'hF0A -> out_rgb=24'hFF00AA.
//  5 Change pos_x 100->300 mid-frame -> no shift until next VS edge; then window starts at x=300.
//  6 pos=(600,460), SHIFT=2 -> sprite clipped at right/bottom; rom_ad never exceeds 1023; no spurious hit in blanking.

Source files
------------

// File: rtl/sprite_rom_fetch.sv
// sprite_rom_fetch: raster-tracking stage in front of a 1024x12 synchronous image ROM.
// It tracks raster x/y from DE/HS/VS and addresses a 32x32 sprite scaled by 2**SHIFT.
// It merges the colour-keyed ROM texels over BG_COLOR to produce RGB888.
// The delayed syncs stay aligned with the pixel, with a fixed latency of 3 cycles.
// Ports:
//   clk, rst_n                   pixel clock, async active-low reset
//   vid_de/vid_hs/vid_vs         input video timing
//   pos_x/pos_y                  sprite top-left, latched on the VS active edge
//   rom_ad/rom_ce/rom_oce/rom_wre/rom_dout   ROM interface (1-cycle read)
//   out_de/out_hs/out_vs/out_rgb delayed timing and RGB888 pixel
module sprite_rom_fetch #(
   parameter int unsigned IMG_W     = 32,
   parameter int unsigned IMG_H     = 32,
   parameter int unsigned SHIFT     = 2,
   parameter logic        SYNC_POL  = 1'b0,
   parameter logic [23:0] BG_COLOR  = 24'h000000,
   parameter logic [11:0] KEY_COLOR = 12'h000,
   parameter logic        KEY_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vid_de,
   input  logic        vid_hs,
   input  logic        vid_vs,
   input  logic [11:0] pos_x,
   input  logic [11:0] pos_y,
   output logic [9:0]  rom_ad,
   output logic        rom_ce,
   output logic        rom_oce,
   output logic        rom_wre,
   input  logic [11:0] rom_dout,
   output logic        out_de,
   output logic        out_hs,
   output logic        out_vs,
   output logic [23:0] out_rgb
);

   localparam int unsigned CW    = 12;
   localparam int unsigned EW    = CW + 1;
   localparam int unsigned AW    = 10;
   localparam int unsigned XW    = $clog2(IMG_W);
   localparam int unsigned YW    = $clog2(IMG_H);
   localparam int unsigned WIN_W = IMG_W << SHIFT;
   localparam int unsigned WIN_H = IMG_H << SHIFT;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   // stage 0 state: raster counters, frame lock, latched position
   logic          de_q, vs_act_q, frame_ok_q, frame_ok_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
   logic [AW-1:0] rom_ad_q, rom_ad_d;
   // stage 1/2 alignment registers, then output registers
   logic          s1_de_q, s1_hs_q, s1_vs_q, s1_hit_q;
   logic          s2_de_q, s2_hs_q, s2_vs_q, s2_hit_q;
   logic          out_de_q, out_hs_q, out_vs_q;
   logic [23:0]   out_rgb_q, rgb_d;

   logic          vs_act, vs_edge, de_fall, in_x, in_y, hit, key;
   logic [EW-1:0] x_e, y_e, px_e, py_e;
   logic [CW-1:0] dx, dy;
   logic [XW-1:0] col;
   logic [YW-1:0] row;

   assign rom_ce  = 1'b1;
   assign rom_oce = 1'b1;
   assign rom_wre = 1'b0;

   // stage 0: counters, position latch, window test and address
   always_comb begin
      vs_act     = (vid_vs == SYNC_POL);
      vs_edge    = vs_act & ~vs_act_q;
      de_fall    = de_q & ~vid_de;
      x_d        = x_q;
      y_d        = y_q;
      px_d       = px_q;
      py_d       = py_q;
      frame_ok_d = frame_ok_q;

      if (!vid_de)          x_d = '0;
      else if (x_q != CMAX) x_d = x_q + 12'd1;

      if (vs_edge)                     y_d = '0;
      else if (de_fall && y_q != CMAX) y_d = y_q + 12'd1;

      if (vs_edge) begin
         frame_ok_d = 1'b1;
         px_d       = pos_x;
         py_d       = pos_y;
      end

      // widened by one bit so px+width cannot wrap near 4095
      x_e  = EW'(x_q);
      y_e  = EW'(y_q);
      px_e = EW'(px_q);
      py_e = EW'(py_q);
      in_x = (x_e >= px_e) && (x_e < px_e + EW'(WIN_W));
      in_y = (y_e >= py_e) && (y_e < py_e + EW'(WIN_H));
      hit  = vid_de & frame_ok_q & in_x & in_y;

      dx  = x_q - px_q;
      dy  = y_q - py_q;
      col = XW'(dx >> SHIFT);
      row = YW'(dy >> SHIFT);
      // IMG_W is a power of two, so row*IMG_W+col is a concatenation
      rom_ad_d = hit ? AW'({row, col}) : rom_ad_q;
   end

   // stage 2: keyed texel expansion (nibble n -> {n,n}) over the background
   always_comb begin
      key   = KEY_EN & (rom_dout == KEY_COLOR);
      rgb_d = 24'h000000;
      if (s2_de_q) begin
         if (s2_hit_q && !key)
            rgb_d = {rom_dout[11:8], rom_dout[11:8], rom_dout[7:4], rom_dout[7:4],
                     rom_dout[3:0], rom_dout[3:0]};
         else
            rgb_d = BG_COLOR;
      end
   end

   // sync pipeline registers reset to the inactive level so no false sync leaks out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q       <= 1'b0;
         vs_act_q   <= 1'b0;
         frame_ok_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         px_q       <= '0;
         py_q       <= '0;
         rom_ad_q   <= '0;
         s1_de_q    <= 1'b0;
         s1_hs_q    <= ~SYNC_POL;
         s1_vs_q    <= ~SYNC_POL;
         s1_hit_q   <= 1'b0;
         s2_de_q    <= 1'b0;
         s2_hs_q    <= ~SYNC_POL;
         s2_vs_q    <= ~SYNC_POL;
         s2_hit_q   <= 1'b0;
         out_de_q   <= 1'b0;
         out_hs_q   <= ~SYNC_POL;
         out_vs_q   <= ~SYNC_POL;
         out_rgb_q  <= 24'h000000;
      end else begin
         de_q       <= vid_de;
         vs_act_q   <= vs_act;
         frame_ok_q <= frame_ok_d;
         x_q        <= x_d;
         y_q        <= y_d;
         px_q       <= px_d;
         py_q       <= py_d;
         rom_ad_q   <= rom_ad_d;
         s1_de_q    <= vid_de;
         s1_hs_q    <= vid_hs;
         s1_vs_q    <= vid_vs;
         s1_hit_q   <= hit;
         s2_de_q    <= s1_de_q;
         s2_hs_q    <= s1_hs_q;
         s2_vs_q    <= s1_vs_q;
         s2_hit_q   <= s1_hit_q;
         out_de_q   <= s2_de_q;
         out_hs_q   <= s2_hs_q;
         out_vs_q   <= s2_vs_q;
         out_rgb_q  <= rgb_d;
      end
   end

   assign rom_ad  = rom_ad_q;
   assign out_de  = out_de_q;
   assign out_hs  = out_hs_q;
   assign out_vs  = out_vs_q;
   assign out_rgb = out_rgb_q;

endmodule

// File: tb/tb_sprite_rom_fetch.sv
// tb_sprite_rom_fetch: directed raster stimulus for sprite_rom_fetch.
// A screen-coordinate model predicts every output pixel 3 cycles ahead.
// Literal pixel/address expectations pin the model itself.
module tb_sprite_rom_fetch;

   localparam logic        SYNC_POL = 1'b0;
   localparam logic        INACT    = ~SYNC_POL;
   localparam logic [23:0] BG       = 24'h000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_de, vid_hs, vid_vs;
   logic [11:0] pos_x, pos_y;
   logic [9:0]  rom_ad;
   logic        rom_ce, rom_oce, rom_wre;
   logic [11:0] rom_dout;
   logic        out_de, out_hs, out_vs;
   logic [23:0] out_rgb;

   sprite_rom_fetch dut (
      .clk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .pos_x(pos_x), .pos_y(pos_y), .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce),
      .rom_wre(rom_wre), .rom_dout(rom_dout), .out_de(out_de), .out_hs(out_hs),
      .out_vs(out_vs), .out_rgb(out_rgb)
   );

   always #5 clk = ~clk;

   // image ROM contents: address 0 is the key colour, 33 is a known texel
   function automatic logic [11:0] rom_val(input int a);
      if (a == 0)  return 12'h000;
      if (a == 33) return 12'hF0A;
      return 12'h800 | 12'(a);
   endfunction

   always @(posedge clk) rom_dout <= rom_val(int'(rom_ad));

   typedef struct {
      logic        de, hs, vs;
      logic [23:0] rgb;
      bit          lit_v;
      logic [23:0] lit_rgb;
      bit          ad_v;
      int          ad;
      bit          lat;
      int          cyc;
   } exp_t;

   typedef struct {
      int          x, y;
      logic [23:0] rgb;
      int          ad;
   } lit_t;

   exp_t q[$];
   lit_t lits[$];
   int   checks = 0, failures = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;
   bit   lat_arm = 1'b0;
   bit   m_locked = 1'b0, m_vs_prev = 1'b0;
   int   m_px = 0, m_py = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] expand(input logic [11:0] t);
      return {t[11:8], t[11:8], t[7:4], t[7:4], t[3:0], t[3:0]};
   endfunction

   // what the pixel at screen (sx,sy) must look like, from the sprite rules
   function automatic logic [23:0] model_rgb(input bit de, input int sx, input int sy);
      logic [11:0] t;
      if (!de) return 24'h000000;
      if (!m_locked) return BG;
      if (sx < m_px || sx >= m_px + 128 || sy < m_py || sy >= m_py + 128) return BG;
      t = rom_val(((sy - m_py) / 4) * 32 + (sx - m_px) / 4);
      if (t == 12'h000) return BG;
      return expand(t);
   endfunction

   task automatic add_lit(input int x, input int y, input logic [23:0] rgb, input int ad);
      lit_t l;
      l.x = x; l.y = y; l.rgb = rgb; l.ad = ad;
      lits.push_back(l);
   endtask

   task automatic step(input bit de, input bit hs, input bit vs, input int sx, input int sy);
      exp_t e;
      bit   vact;
      @(posedge clk); #2;
      vid_de = de; vid_hs = hs; vid_vs = vs;
      e.de = de; e.hs = hs; e.vs = vs;
      e.rgb = model_rgb(de, sx, sy);
      e.lit_v = 1'b0; e.lit_rgb = '0; e.ad_v = 1'b0; e.ad = 0;
      e.lat = lat_arm; e.cyc = cyc;
      if (de) foreach (lits[i]) if (lits[i].x == sx && lits[i].y == sy) begin
         e.lit_v = 1'b1; e.lit_rgb = lits[i].rgb;
         if (lits[i].ad >= 0) begin e.ad_v = 1'b1; e.ad = lits[i].ad; end
      end
      q.push_back(e);
      vact = (vs == SYNC_POL);
      if (vact && !m_vs_prev) begin m_locked = 1'b1; m_px = int'(pos_x); m_py = int'(pos_y); end
      m_vs_prev = vact;
   endtask

   task automatic hline(input int len, input int sy);
      for (int i = 0; i < len; i++) step(1'b1, INACT, INACT, i, sy);
      for (int i = 0; i < 8; i++) step(1'b0, (i == 2 || i == 3) ? SYNC_POL : INACT, INACT, -1, -1);
   endtask

   task automatic vsync();
      for (int i = 0; i < 11; i++) step(1'b0, INACT, (i >= 4 && i < 7) ? SYNC_POL : INACT, -1, -1);
   endtask

   task automatic frame(input int nlines, input int full_from, input int short_len,
                        input int full_len, input int chg_line);
      for (int l = 0; l < nlines; l++) begin
         if (l == chg_line) pos_x = 12'd300;
         hline((l < full_from) ? short_len : full_len, l);
      end
   endtask

   task automatic release_reset();
      exp_t e;
      @(posedge clk); #3;
      vid_de = 1'b0; vid_hs = INACT; vid_vs = INACT;
      rst_n = 1'b1;
      e.de = 1'b0; e.hs = INACT; e.vs = INACT; e.rgb = '0;
      e.lit_v = 1'b0; e.lit_rgb = '0; e.ad_v = 1'b0; e.ad = 0; e.lat = 1'b0; e.cyc = 0;
      q.delete();
      repeat (3) q.push_back(e);
      m_locked = 1'b0; m_vs_prev = 1'b0;
      chk_en = 1'b1;
   endtask

   // single compare process
   logic prev_de = 1'b0;
   always @(negedge clk or negedge rst_n) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         checks++;
         if (out_de !== 1'b0 || out_rgb !== 24'h0 || out_hs !== INACT || out_vs !== INACT ||
             rom_ad !== 10'd0 || rom_ce !== 1'b1 || rom_oce !== 1'b1 || rom_wre !== 1'b0) begin
            failures++;
            $display("FAIL reset: de=%b hs=%b vs=%b rgb=%h ad=%0d ce=%b oce=%b wre=%b, want 0 1 1 000000 0 1 1 0",
                     out_de, out_hs, out_vs, out_rgb, rom_ad, rom_ce, rom_oce, rom_wre);
         end
      end else if (chk_en) begin
         if (q.size() >= 2 && q[q.size()-2].ad_v) begin
            checks++;
            if (int'(rom_ad) != q[q.size()-2].ad) begin
               failures++;
               $display("FAIL rom_ad: got %0d want %0d", rom_ad, q[q.size()-2].ad);
            end
         end
         if (q.size() >= 4) begin
            e = q.pop_front();
            checks++;
            if (out_de !== e.de || out_hs !== e.hs || out_vs !== e.vs || out_rgb !== e.rgb ||
                rom_wre !== 1'b0 || rom_ce !== 1'b1 || rom_oce !== 1'b1) begin
               failures++;
               $display("FAIL pixel @%0d: got de=%b hs=%b vs=%b rgb=%h want de=%b hs=%b vs=%b rgb=%h",
                        cyc, out_de, out_hs, out_vs, out_rgb, e.de, e.hs, e.vs, e.rgb);
            end
            if (e.lit_v) begin
               checks++;
               if (out_de !== 1'b1 || out_rgb !== e.lit_rgb) begin
                  failures++;
                  $display("FAIL literal: got de=%b rgb=%h want de=1 rgb=%h", out_de, out_rgb, e.lit_rgb);
               end
            end
            if (e.lat) begin
               checks++;
               if (out_de !== 1'b1 || prev_de !== 1'b0 || cyc - e.cyc != 3) begin
                  failures++;
                  $display("FAIL latency: rise de=%b prev=%b after %0d cycles, want rise after 3",
                           out_de, prev_de, cyc - e.cyc);
               end
            end
         end
      end
      prev_de = out_de;
   end

   initial begin
      rst_n = 1'b0;
      vid_de = 1'b0; vid_hs = INACT; vid_vs = INACT;
      pos_x = 12'd0; pos_y = 12'd0;
      // reset held with random timing inputs
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         vid_de = 1'($urandom); vid_hs = 1'($urandom); vid_vs = 1'($urandom);
      end
      release_reset();
      // no VS seen yet: background only
      frame(3, 0, 0, 40, -1);

      // latency and first texels with the sprite at the origin
      vsync();
      lits.delete();
      add_lit(0, 0, 24'h000000, 0);
      add_lit(4, 1, 24'h880011, 1);
      lat_arm = 1'b1;
      step(1'b1, INACT, INACT, 0, 0);
      lat_arm = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, (i == 2 || i == 3) ? SYNC_POL : INACT, INACT, -1, -1);
      hline(8, 1);

      // 640-wide lines, sprite at (100,50); pos_x moves mid-frame
      pos_x = 12'd100; pos_y = 12'd50;
      vsync();
      lits.delete();
      add_lit(99, 50, 24'h000000, -1);
      add_lit(100, 50, 24'h000000, 0);
      add_lit(104, 50, 24'h880011, 1);
      add_lit(104, 54, 24'hFF00AA, 33);
      add_lit(227, 56, 24'h8833FF, 63);
      add_lit(228, 50, 24'h000000, -1);
      frame(57, 50, 4, 640, 52);

      // new position takes effect after the VS edge
      vsync();
      lits.delete();
      add_lit(104, 50, 24'h000000, -1);
      add_lit(299, 50, 24'h000000, -1);
      add_lit(300, 50, 24'h000000, 0);
      add_lit(304, 50, 24'h880011, 1);
      add_lit(427, 51, 24'h8811FF, 31);
      add_lit(428, 51, 24'h000000, -1);
      frame(52, 50, 4, 640, -1);

      // clipped at right/bottom edges of 640x480
      pos_x = 12'd600; pos_y = 12'd460;
      vsync();
      lits.delete();
      add_lit(599, 460, 24'h000000, -1);
      add_lit(604, 460, 24'h880011, 1);
      add_lit(600, 479, 24'h888800, 128);
      add_lit(639, 479, 24'h888899, 137);
      frame(480, 455, 2, 640, -1);
      vsync();

      // reset in the middle of a line
      lits.delete();
      for (int i = 0; i < 20; i++) step(1'b1, INACT, INACT, i, 0);
      @(posedge clk); #2;
      chk_en = 1'b0;
      q.delete();
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #2;
         vid_de = 1'($urandom); vid_hs = 1'($urandom); vid_vs = 1'($urandom);
      end
      release_reset();
      frame(2, 0, 0, 640, -1);
      vsync();
      frame(2, 0, 2, 2, -1);
      repeat (6) step(1'b0, INACT, INACT, -1, -1);
      @(posedge clk); #8;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
